regf_resp_writer: RTL and testbench



---
 rtl/i3c_regf_pkg.sv | 52 +++++
 rtl/regf_resp_writer.sv | 148 ++++++++++++++
 tb/tb_regf_resp_writer.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/i3c_regf_pkg.sv
// Shared register-file definitions: response descriptor layout, error codes
// and the response-writer state encoding.
package i3c_regf_pkg;

  localparam int unsigned RESP_DESC_W     = 32;
  localparam int unsigned RESP_DESC_BYTES = 4;

  localparam int unsigned RESP_ERR_MSB = 31;
  localparam int unsigned RESP_ERR_LSB = 28;
  localparam int unsigned RESP_TID_MSB = 27;
  localparam int unsigned RESP_TID_LSB = 24;
  localparam int unsigned RESP_LEN_MSB = 15;
  localparam int unsigned RESP_LEN_LSB = 0;

  localparam logic [3:0] RESP_ERR_SUCCESS   = 4'h0;
  localparam logic [3:0] RESP_ERR_CRC       = 4'h1;
  localparam logic [3:0] RESP_ERR_PARITY    = 4'h2;
  localparam logic [3:0] RESP_ERR_FRAME     = 4'h3;
  localparam logic [3:0] RESP_ERR_ADDR_NACK = 4'h4;
  localparam logic [3:0] RESP_ERR_OVERFLOW  = 4'h5;
  localparam logic [3:0] RESP_ERR_NACK      = 4'h6;
  localparam logic [3:0] RESP_ERR_ABORTED   = 4'h8;
  localparam logic [3:0] RESP_ERR_NOT_SUPP  = 4'h9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } rspw_state_e;

  // Reserved bits [23:16] stay zero.
  function automatic logic [RESP_DESC_W-1:0] pack_resp_desc(
    input logic [3:0]  err,
    input logic [3:0]  tid,
    input logic [15:0] len
  );
    logic [RESP_DESC_W-1:0] d;
    d = '0;
    d[RESP_ERR_MSB:RESP_ERR_LSB] = err;
    d[RESP_TID_MSB:RESP_TID_LSB] = tid;
    d[RESP_LEN_MSB:RESP_LEN_LSB] = len;
    return d;
  endfunction

  function automatic logic [7:0] resp_desc_byte(
    input logic [RESP_DESC_W-1:0] d,
    input logic [1:0]             k
  );
    return 8'(d >> {k, 3'b000});
  endfunction

endpackage

// File: rtl/regf_resp_writer.sv
// Packs engine response fields into a 32-bit descriptor and writes it
// little-endian, one byte at a time, through the shared reg_file write port.
module regf_resp_writer
  import i3c_regf_pkg::*;
#(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned WR_HOLD = 2
) (
  input  logic              i_rspw_clk,
  input  logic              i_rspw_rst_n,
  input  logic              i_engine_resp_valid,
  input  logic [3:0]        i_engine_TID,
  input  logic [3:0]        i_engine_err_status,
  input  logic [15:0]       i_engine_data_len,
  input  logic [ADDR_W-1:0] i_engine_resp_addr,
  input  logic              i_rspw_stall,
  output logic              o_rspw_ready,
  output logic              o_rspw_done,
  output logic              o_rspw_overrun,
  output logic              o_regf_wr_en,
  output logic [ADDR_W-1:0] o_regf_addr,
  output logic [7:0]        o_regf_data_wr
);

  localparam int unsigned HOLD_W = (WR_HOLD > 1) ? $clog2(WR_HOLD) : 1;
  localparam int unsigned IDX_W  = 2;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(WR_HOLD - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(RESP_DESC_BYTES - 1);

  rspw_state_e            state_q, state_d;
  logic [RESP_DESC_W-1:0] desc_q, desc_d;
  logic [ADDR_W-1:0]      base_q, base_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [HOLD_W-1:0]      hold_q, hold_d;
  logic                   ready_q, ready_d;
  logic                   done_q, done_d;
  logic                   overrun_q, overrun_d;
  logic                   wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [7:0]             data_q, data_d;
  logic [RESP_DESC_W-1:0] new_desc;
  logic [IDX_W-1:0]       idx_next;

  assign new_desc = pack_resp_desc(i_engine_err_status, i_engine_TID, i_engine_data_len);
  assign idx_next = idx_q + IDX_W'(1);

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    desc_d    = desc_q;
    base_d    = base_q;
    idx_d     = idx_q;
    hold_d    = hold_q;
    ready_d   = ready_q;
    done_d    = 1'b0;
    overrun_d = overrun_q;
    wr_en_d   = wr_en_q;
    addr_d    = addr_q;
    data_d    = data_q;

    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        wr_en_d = 1'b0;
        if (i_engine_resp_valid) begin
          state_d = WRITE;
          desc_d  = new_desc;
          base_d  = i_engine_resp_addr;
          idx_d   = '0;
          hold_d  = '0;
          ready_d = 1'b0;
          wr_en_d = 1'b1;
          addr_d  = i_engine_resp_addr;
          data_d  = resp_desc_byte(new_desc, 2'd0);
        end
      end
      WRITE: begin
        if (i_engine_resp_valid) overrun_d = 1'b1;
        // A stalled cycle freezes the byte and its hold count.
        if (!i_rspw_stall) begin
          if (hold_q == HOLD_LAST) begin
            if (idx_q == IDX_LAST) begin
              state_d = DONE;
              wr_en_d = 1'b0;
              done_d  = 1'b1;
              idx_d   = '0;
              hold_d  = '0;
            end else begin
              idx_d  = idx_next;
              hold_d = '0;
              addr_d = base_q + ADDR_W'(idx_next);
              data_d = resp_desc_byte(desc_q, idx_next);
            end
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
      end
      DONE: begin
        if (i_engine_resp_valid) overrun_d = 1'b1;
        state_d = IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
        wr_en_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_rspw_clk or negedge i_rspw_rst_n) begin
    if (!i_rspw_rst_n) begin
      state_q   <= IDLE;
      desc_q    <= '0;
      base_q    <= '0;
      idx_q     <= '0;
      hold_q    <= '0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      wr_en_q   <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      desc_q    <= desc_d;
      base_q    <= base_d;
      idx_q     <= idx_d;
      hold_q    <= hold_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
      wr_en_q   <= wr_en_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
    end
  end

  // The host owns the port during a stall cycle, so the enable yields at once.
  assign o_regf_wr_en   = wr_en_q & ~i_rspw_stall;
  assign o_rspw_ready   = ready_q;
  assign o_rspw_done    = done_q;
  assign o_rspw_overrun = overrun_q;
  assign o_regf_addr    = addr_q;
  assign o_regf_data_wr = data_q;

endmodule

// File: tb/tb_regf_resp_writer.sv
// Directed and randomized bench for regf_resp_writer against a write-trace
// model built from the descriptor layout and hold/stall rules.
module tb_regf_resp_writer;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned H      = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              valid = 1'b0;
  logic [3:0]        tid_i = '0;
  logic [3:0]        err_i = '0;
  logic [15:0]       len_i = '0;
  logic [ADDR_W-1:0] base_i = '0;
  logic              stall = 1'b0;
  logic              ready, done, overrun, wr_en;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        data;

  int checks = 0;
  int failures = 0;

  regf_resp_writer #(.ADDR_W(ADDR_W), .WR_HOLD(H)) dut (
    .i_rspw_clk          (clk),
    .i_rspw_rst_n        (rst_n),
    .i_engine_resp_valid (valid),
    .i_engine_TID        (tid_i),
    .i_engine_err_status (err_i),
    .i_engine_data_len   (len_i),
    .i_engine_resp_addr  (base_i),
    .i_rspw_stall        (stall),
    .o_rspw_ready        (ready),
    .o_rspw_done         (done),
    .o_rspw_overrun      (overrun),
    .o_regf_wr_en        (wr_en),
    .o_regf_addr         (addr),
    .o_regf_data_wr      (data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // stall_mode: 0 none, 1 window [st_lo, st_hi], 2 random per cycle.
  // extra_n: cycle (after accept) carrying a second request; rst_at: cycle to reset in.
  task automatic run_txn(input logic [3:0] tid, input logic [3:0] err,
                         input logic [15:0] len, input logic [ADDR_W-1:0] base,
                         input int stall_mode, input int st_lo, input int st_hi,
                         input int extra_n, input int rst_at, input logic exp_ovr);
    logic [31:0]          d;
    logic [ADDR_W+7:0]    exp_q[$];
    logic [ADDR_W+7:0]    obs_q[$];
    logic [ADDR_W-1:0]    a;
    logic [7:0]           b;
    int n, written, stalls, stalled_wr, done_n, exp_done;
    logic ready_at_done;

    d = {err, tid, 8'h00, len};
    for (int k = 0; k < 4; k++) begin
      a = base + ADDR_W'(k);
      b = d[8*k +: 8];
      for (int h = 0; h < int'(H); h++) exp_q.push_back({a, b});
    end
    written = 0; stalls = 0; stalled_wr = 0; done_n = -1; ready_at_done = 1'b1;

    @(posedge clk); #1;
    stall = 1'b0;
    check("ready_before_accept", 32'(ready), 32'd1);
    check("done_single_cycle", 32'(done), 32'd0);
    tid_i = tid; err_i = err; len_i = len; base_i = base; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    n = 1;
    while (n < 200) begin
      case (stall_mode)
        1:       stall = (n >= st_lo) && (n <= st_hi);
        2:       stall = ($urandom_range(0, 2) == 0);
        default: stall = 1'b0;
      endcase
      if (written < 4 * int'(H)) begin
        if (stall) stalls++;
        else written++;
      end
      valid = (n == extra_n);
      if (valid) begin
        tid_i = ~tid; err_i = ~err; len_i = ~len; base_i = base + ADDR_W'(8);
      end
      if (n == rst_at) begin
        rst_n = 1'b0;
        #1;
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_addr", 32'(addr), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_partial_writes", 32'(obs_q.size()), 32'(rst_at - 1));
        stall = 1'b0;
        valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      @(negedge clk);
      if (wr_en) obs_q.push_back({addr, data});
      if (stall && wr_en) stalled_wr++;
      if (done) begin
        done_n = n;
        ready_at_done = ready;
        break;
      end
      @(posedge clk); #1;
      n++;
    end

    exp_done = 4 * int'(H) + 1 + stalls;
    check("done_latency", 32'(done_n), 32'(exp_done));
    check("write_count", 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      check($sformatf("write_%0d", i), 32'(obs_q[i]), 32'(exp_q[i]));
    check("stalled_writes", 32'(stalled_wr), 32'd0);
    check("ready_in_done", 32'(ready_at_done), 32'd0);
    check("overrun", 32'(overrun), 32'(exp_ovr));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ready", 32'(ready), 32'd1);
    check("reset_done", 32'(done), 32'd0);
    check("reset_overrun", 32'(overrun), 32'd0);
    check("reset_wr_en", 32'(wr_en), 32'd0);
    check("reset_addr", 32'(addr), 32'd0);
    check("reset_data", 32'(data), 32'd0);
    rst_n = 1'b1;

    // Basic transfer, then a wrapping one accepted on the first ready cycle.
    run_txn(4'h5, 4'h0, 16'h0123, 12'd1000, 0, 0, 0, 0, 0, 1'b0);
    run_txn(4'h3, 4'h9, 16'hBEEF, 12'd4094, 0, 0, 0, 0, 0, 1'b0);

    // Stall three cycles while byte 1 is on the port.
    run_txn(4'hA, 4'h1, 16'h4567, 12'd300, 1, int'(H) + 1, int'(H) + 3, 0, 0, 1'b0);

    // Random fields and random stalls.
    for (int t = 0; t < 6; t++)
      run_txn(4'($urandom), 4'($urandom), 16'($urandom), 12'($urandom),
              2, 0, 0, 0, 0, 1'b0);

    // Request while busy: ignored, overrun sticks.
    run_txn(4'h7, 4'h2, 16'h1234, 12'd64, 0, 0, 0, 2, 0, 1'b1);
    run_txn(4'($urandom), 4'($urandom), 16'($urandom), 12'($urandom),
            2, 0, 0, 0, 0, 1'b1);

    // Reset during byte 2, then a clean transfer from base 200.
    run_txn(4'hC, 4'h4, 16'hCAFE, 12'd500, 0, 0, 0, 0, 2 * int'(H) + 1, 1'b1);
    run_txn(4'h1, 4'h0, 16'h00FF, 12'd200, 0, 0, 0, 0, 0, 1'b0);

    // Request in the same cycle done is high: ignored, flags overrun.
    run_txn(4'h6, 4'h0, 16'h5A5A, 12'd10, 0, 0, 0, 4 * int'(H) + 1, 0, 1'b0);
    @(posedge clk); #1;
    valid = 1'b0;
    check("done_req_overrun", 32'(overrun), 32'd1);
    check("done_req_ready", 32'(ready), 32'd1);
    @(negedge clk);
    check("done_req_no_write", 32'(wr_en), 32'd0);
    @(posedge clk); #1;
    check("done_req_idle", 32'(ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
